// File: rtl/apb_master_bridge_if.sv
// Command/response stream plus APB requester pins of the bridge, grouped as one bundle.
// "master" is the bridge's view; "slave" is the view of whatever surrounds it (command source, response sink, APB slave).
interface apb_master_bridge_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB requester: command accepted at edge N -> response from edge N+2+waits (or N+1+TIMEOUT on timeout).
// Backpressure: cmd_ready is low while busy or while an untaken response sits in the one-entry slot.
module apb_master_bridge #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                 pclk,
  input  logic                 preset,
  apb_master_bridge_if.master  bus
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic                  cmd_ready;

  assign cmd_ready = !preset && (state_q == IDLE) && !rsp_valid_q;

  always_comb begin
    state_d       = state_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    wait_d        = wait_q;

    if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready) begin
          pwrite_d = bus.cmd_write;
          paddr_d  = bus.cmd_addr;
          pwdata_d = bus.cmd_wdata;
          psel_d   = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        wait_d    = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (bus.pready) begin
          rsp_rdata_d   = pwrite_q ? '0 : bus.prdata;
          rsp_err_d     = bus.pslverr;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = IDLE;
        end else if (wait_q == WAIT_LAST) begin
          // A hung slave still yields exactly one response, flagged as an error.
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = IDLE;
        end else if (wait_q != '1) begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q       <= IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      wait_q        <= '0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      wait_q        <= wait_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready;
  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: drives commands, emulates an 8-bit APB memory slave with programmable wait states,
// and predicts each response from a transaction-level memory model.
module tb_apb_master_bridge;

  localparam int TO = 4;

  logic pclk;
  logic preset;
  int   n_checks;
  int   n_pass;

  // Prediction model: what memory contents the command stream implies.
  logic [7:0] ref_mem [256];
  bit         ref_ok  [256];
  // Slave-side storage, written only from what appears on the APB pins.
  logic [7:0] slv_mem [256];
  bit         slv_ok  [256];

  apb_master_bridge_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

  apb_master_bridge #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .TIMEOUT(TO)) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Issue one command; the slave answers after 'waits' ACCESS cycles (waits >= TO never answers).
  // The response is then held for 'rdly' cycles with rsp_ready low and cmd_valid asserted.
  task automatic do_cmd(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                        input int waits, input int rdly);
    logic [7:0] exp_rdata;
    logic       exp_err;
    logic       exp_to;
    int         exp_lat;
    int         lat;
    int         acc;
    int         cyc;
    bit         seen;

    exp_to  = (waits >= TO);
    exp_lat = exp_to ? 1 + TO : 2 + waits;
    if (exp_to) begin
      exp_rdata = 8'h00; exp_err = 1'b1;
    end else if (wr) begin
      exp_rdata = 8'h00; exp_err = 1'b0;
      ref_mem[addr] = wdata; ref_ok[addr] = 1'b1;
    end else begin
      exp_rdata = ref_ok[addr] ? ref_mem[addr] : 8'hEE;
      exp_err   = !ref_ok[addr];
    end

    bus.rsp_ready = (rdly == 0);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    #1;
    cyc = 0;
    while (!bus.cmd_ready && cyc < 20) begin
      @(negedge pclk);
      cyc++;
    end
    chk("accept_ready", bus.cmd_ready, 1);
    @(posedge pclk);
    #1 bus.cmd_valid = 1'b0;

    seen = 0; lat = 0; acc = 0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge pclk);
      if (bus.rsp_valid) begin
        seen = 1;
        lat  = c - 1;
        bus.pready = 1'b0;
      end else begin
        chk("psel_hi", bus.psel, 1);
        chk("penable", bus.penable, (c >= 2));
        chk("paddr_stable", bus.paddr, addr);
        chk("pwrite_stable", bus.pwrite, wr);
        chk("pwdata_stable", bus.pwdata, wdata);
        bus.prdata  = 8'($urandom);
        bus.pslverr = 1'($urandom);
        bus.pready  = 1'b0;
        if (bus.psel && bus.penable) begin
          if (acc == waits) begin
            bus.pready = 1'b1;
            if (bus.pwrite) begin
              slv_mem[bus.paddr] = bus.pwdata;
              slv_ok[bus.paddr]  = 1'b1;
              bus.prdata  = 8'($urandom_range(1, 255));
              bus.pslverr = 1'b0;
            end else begin
              bus.prdata  = slv_ok[bus.paddr] ? slv_mem[bus.paddr] : 8'hEE;
              bus.pslverr = !slv_ok[bus.paddr];
            end
          end
          acc++;
        end
      end
    end
    chk("rsp_arrived", seen, 1);
    chk("rsp_latency", lat, exp_lat);
    chk("bus_idle_psel", bus.psel, 0);
    chk("bus_idle_penable", bus.penable, 0);
    chk("rsp_rdata", bus.rsp_rdata, exp_rdata);
    chk("rsp_err", bus.rsp_err, exp_err);
    chk("rsp_timeout", bus.rsp_timeout, exp_to);
    chk("busy_no_ready", bus.cmd_ready, 0);

    if (rdly > 0) begin
      bus.cmd_valid = 1'b1;
      for (int d = 1; d < rdly; d++) begin
        @(negedge pclk);
        chk("bp_cmd_ready", bus.cmd_ready, 0);
        chk("bp_rsp_valid", bus.rsp_valid, 1);
        chk("bp_rdata", bus.rsp_rdata, exp_rdata);
        chk("bp_err", bus.rsp_err, exp_err);
        chk("bp_timeout", bus.rsp_timeout, exp_to);
      end
      bus.rsp_ready = 1'b1;
    end
    @(negedge pclk);
    chk("rsp_drained", bus.rsp_valid, 0);
    chk("ready_after_drain", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic reset_mid_access();
    int cyc;
    bus.rsp_ready = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 8'h60;
    bus.cmd_wdata = 8'h99;
    #1;
    cyc = 0;
    while (!bus.cmd_ready && cyc < 20) begin
      @(negedge pclk);
      cyc++;
    end
    chk("rst_accept", bus.cmd_ready, 1);
    @(posedge pclk);
    #1 bus.cmd_valid = 1'b0;
    bus.pready = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
    chk("rst_in_access", bus.penable, 1);
    preset = 1'b1;
    @(negedge pclk);
    chk("rst_psel", bus.psel, 0);
    chk("rst_penable", bus.penable, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_cmd_ready_low", bus.cmd_ready, 0);
    preset = 1'b0;
    #1;
    chk("rst_cmd_ready_back", bus.cmd_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      chk("rst_no_rsp", bus.rsp_valid, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    preset        = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 8'h00;
    bus.cmd_wdata = 8'h00;
    bus.rsp_ready = 1'b1;
    bus.prdata    = 8'h00;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;

    repeat (3) @(negedge pclk);
    chk("reset_psel", bus.psel, 0);
    chk("reset_penable", bus.penable, 0);
    chk("reset_pwrite", bus.pwrite, 0);
    chk("reset_paddr", bus.paddr, 0);
    chk("reset_pwdata", bus.pwdata, 0);
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 0);
    chk("reset_rsp_err", bus.rsp_err, 0);
    chk("reset_rsp_timeout", bus.rsp_timeout, 0);
    chk("reset_cmd_ready", bus.cmd_ready, 0);
    preset = 1'b0;
    #1;
    chk("post_reset_ready", bus.cmd_ready, 1);
    @(negedge pclk);

    do_cmd(1'b1, 8'h10, 8'hA5, 0, 0);   // zero-wait write
    do_cmd(1'b0, 8'h10, 8'h00, 0, 0);   // read-back
    do_cmd(1'b0, 8'h20, 8'h00, 0, 0);   // unwritten -> slave error
    do_cmd(1'b1, 8'h30, 8'h3C, 0, 0);
    do_cmd(1'b0, 8'h30, 8'h00, 3, 1);   // three wait states
    do_cmd(1'b0, 8'h40, 8'h00, 99, 0);  // hung slave
    do_cmd(1'b1, 8'h41, 8'h5A, TO, 2);  // timed-out write must not commit
    do_cmd(1'b0, 8'h41, 8'h00, TO - 1, 0);
    do_cmd(1'b1, 8'h50, 8'h77, 0, 5);   // response backpressure
    reset_mid_access();
    do_cmd(1'b0, 8'h60, 8'h00, 0, 0);   // aborted write left no trace
    do_cmd(1'b0, 8'h50, 8'h00, 1, 0);

    for (int i = 0; i < 80; i++) begin
      do_cmd(1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom),
             $urandom_range(0, TO + 2), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
